// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch buffer between the instruction memory port
// and the IF/ID register. Requests are issued in PC order; capacity is
// reserved at request time (entries + in-flight < DEPTH), so a response
// always finds a free slot. A redirect flushes the buffer and turns every
// outstanding request into a response to be dropped.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,

  output logic        req_valid,
  output logic [63:0] req_addr,
  input  logic        req_ready,

  input  logic        resp_valid,
  input  logic [31:0] resp_ins,

  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_ins,
  input  logic        out_ready,

  input  logic        redirect,
  input  logic [63:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  // architectural state
  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   resp_pc_q,  resp_pc_d;
  logic [CW-1:0] count_q,    count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q,     drop_d;
  logic [AW-1:0] head_q,     head_d;
  logic [AW-1:0] tail_q,     tail_d;

  // entry storage
  logic [DEPTH-1:0][63:0] pc_mem_q;
  logic [DEPTH-1:0][31:0] ins_mem_q;

  // per-cycle events
  logic        req_fire;
  logic        resp_take;
  logic        resp_drop;
  logic        push;
  logic        pop;
  logic [CW:0] occupancy;
  logic [63:0] redir_pc_al;

  // Handshake decode. A response with nothing in flight has no matching
  // request and is ignored outright. Redirect blocks new requests, pops
  // and pushes; a same-cycle response is still retired from inflight.
  always_comb begin
    occupancy   = {1'b0, count_q} + {1'b0, inflight_q};
    req_valid   = reset & ~redirect & (occupancy < DEPTH_W);
    req_addr    = fetch_pc_q;
    req_fire    = req_valid & req_ready;
    resp_take   = resp_valid & (inflight_q != '0);
    resp_drop   = resp_take & (drop_q != '0);
    push        = resp_take & (drop_q == '0) & ~redirect;
    pop         = (count_q != '0) & out_ready & ~redirect;
    redir_pc_al = {redirect_pc[63:2], 2'b00};
  end

  // Next-state computation for pointers, counters and PCs.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;

    if (redirect) begin
      // Everything still outstanding after this cycle's response becomes
      // a response to drop; drop_cnt is a subset of inflight, so prior
      // redirects' drops are covered automatically.
      fetch_pc_d = redir_pc_al;
      resp_pc_d  = redir_pc_al;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      inflight_d = inflight_q - CW'(resp_take);
      drop_d     = inflight_q - CW'(resp_take);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
      if (push) begin
        resp_pc_d = resp_pc_q + 64'd4;
        tail_d    = tail_q + AW'(1);
      end
      if (pop) head_d = head_q + AW'(1);
      if (resp_drop) drop_d = drop_q - CW'(1);
      count_d    = count_q + CW'(push) - CW'(pop);
      inflight_d = inflight_q + CW'(req_fire) - CW'(resp_take);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Entry write at tail on a kept response, tagged with the expected PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_mem_q  <= '0;
      ins_mem_q <= '0;
    end else if (push) begin
      pc_mem_q[tail_q]  <= resp_pc_q;
      ins_mem_q[tail_q] <= resp_ins;
    end
  end

  // Head presentation; outputs forced to zero when the buffer is empty.
  always_comb begin
    out_valid = (count_q != '0);
    out_pc    = '0;
    out_ins   = '0;
    if (out_valid) begin
      out_pc  = pc_mem_q[head_q];
      out_ins = ins_mem_q[head_q];
    end
  end

endmodule
